// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel PWM sharing one edge/centre-aligned period counter.
// Period, duty and mode are double-buffered and only swap in at a period boundary.
module pwm_multi_channel #(
    parameter int               NCH        = 4,
    parameter int               CNT_W      = 24,
    parameter int unsigned      PERIOD_RST = 50000,
    parameter logic [NCH-1:0]   POL        = '0
) (
    input  logic                 CLK,
    input  logic                 Rstn,
    input  logic                 en,
    input  logic                 upd,
    input  logic [CNT_W-1:0]     period_in,
    input  logic [NCH*CNT_W-1:0] duty_in,
    input  logic                 mode_in,
    output logic [NCH-1:0]       pwm_out,
    output logic                 period_end,
    output logic                 upd_pending
);
    logic [CNT_W-1:0]     cnt, cnt_nx, per, per_p;
    logic [NCH*CNT_W-1:0] duty, duty_p;
    logic                 mode, mode_p, dir, dir_nx, bnd, degen, at_top;
    logic [CNT_W:0]       pm1;
    logic [NCH-1:0]       raw;

    // P-1 kept one bit wider so P=0 cannot wrap into a reachable count
    assign pm1    = {1'b0, per} - (CNT_W+1)'(1);
    assign degen  = per < CNT_W'(2);
    assign at_top = {1'b0, cnt} == pm1;

    always_comb begin
        bnd    = degen || (mode ? (cnt == CNT_W'(1) && (dir || per == CNT_W'(2))) : at_top);
        dir_nx = bnd ? 1'b0 : (mode && at_top) ? 1'b1 : dir;
        cnt_nx = bnd ? '0 : dir_nx ? cnt - CNT_W'(1) : cnt + CNT_W'(1);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_cmp
        assign raw[i] = cnt < duty[i*CNT_W +: CNT_W];
    end

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            cnt         <= '0;
            dir         <= 1'b0;
            per         <= CNT_W'(PERIOD_RST);
            duty        <= '0;
            mode        <= 1'b0;
            per_p       <= '0;
            duty_p      <= '0;
            mode_p      <= 1'b0;
            upd_pending <= 1'b0;
            period_end  <= 1'b0;
            pwm_out     <= POL;
        end else if (!en) begin
            cnt        <= '0;
            dir        <= 1'b0;
            period_end <= 1'b0;
            pwm_out    <= POL;
            // while stopped there is no glitch risk, so updates go straight to the active set
            if (upd) begin
                per         <= period_in;
                duty        <= duty_in;
                mode        <= mode_in;
                upd_pending <= 1'b0;
            end
        end else begin
            cnt        <= cnt_nx;
            dir        <= dir_nx;
            period_end <= bnd;
            pwm_out    <= raw ^ POL;
            if (bnd && upd_pending) begin
                per         <= per_p;
                duty        <= duty_p;
                mode        <= mode_p;
                upd_pending <= 1'b0;
            end
            // a write on the boundary cycle itself waits for the following boundary
            if (upd) begin
                per_p       <= period_in;
                duty_p      <= duty_in;
                mode_p      <= mode_in;
                upd_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_pwm_multi_channel;
    localparam int NCH   = 4;
    localparam int CNT_W = 24;
    localparam logic [NCH-1:0] POLV = 4'b0010;

    logic                 CLK = 1'b0, Rstn = 1'b0, en = 1'b0, upd = 1'b0, mode_in = 1'b0;
    logic [CNT_W-1:0]     period_in = '0;
    logic [NCH*CNT_W-1:0] duty_in = '0;
    logic [NCH-1:0]       pwm_out;
    logic                 period_end, upd_pending;

    typedef struct {int cyc; int tag; logic [5:0] exp;} ent_t;
    ent_t q[$];
    int cyc = 0, n_cmp = 0, n_bad = 0;
    int cseq[10] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};

    pwm_multi_channel #(.NCH(NCH), .CNT_W(CNT_W), .PERIOD_RST(50000), .POL(POLV)) dut (
        .CLK(CLK), .Rstn(Rstn), .en(en), .upd(upd), .period_in(period_in),
        .duty_in(duty_in), .mode_in(mode_in), .pwm_out(pwm_out),
        .period_end(period_end), .upd_pending(upd_pending)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin : mon
        ent_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if ({pwm_out, period_end, upd_pending} !== e.exp || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL t%0d cyc%0d: got pwm=%b pe=%b up=%b, want pwm=%b pe=%b up=%b (for cyc%0d)",
                         e.tag, cyc, pwm_out, period_end, upd_pending,
                         e.exp[5:2], e.exp[1], e.exp[0], e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations left", q.size());
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input int tag, input logic [3:0] p, input logic pe, input logic up);
        q.push_back('{cyc + 1, tag, {p, pe, up}});
        tick();
    endtask

    task automatic cfg(input int p, input logic m, input int d3, input int d2, input int d1, input int d0);
        period_in = CNT_W'(p);
        mode_in   = m;
        duty_in   = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    endtask

    initial begin
        int s, d;
        logic up;
        // reset held, then released with en=0
        tick();
        step(0, POLV, 1'b0, 1'b0);
        step(0, POLV, 1'b0, 1'b0);
        Rstn = 1'b1;
        step(0, POLV, 1'b0, 1'b0);
        step(0, POLV, 1'b0, 1'b0);

        // edge P=10: ch0=3, ch1=P (inverted), ch2=0, ch3=P+5
        cfg(10, 1'b0, 15, 0, 10, 3);
        upd = 1'b1;
        step(1, POLV, 1'b0, 1'b0);
        upd = 1'b0;
        en  = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            s = (j - 1) % 10;
            step(1, {3'b100, (s < 3)}, (j % 10 == 0), 1'b0);
        end

        // mid-period update, boundary-cycle update, overwrite of pending
        for (int j = 31; j <= 100; j++) begin
            s   = (j - 1) % 10;
            upd = (j == 33 || j == 60 || j == 83 || j == 85);
            if (j == 33) duty_in[CNT_W-1:0] = CNT_W'(8);
            if (j == 60) duty_in[CNT_W-1:0] = CNT_W'(5);
            if (j == 83) duty_in[CNT_W-1:0] = CNT_W'(9);
            if (j == 85) duty_in[CNT_W-1:0] = CNT_W'(2);
            d  = (j <= 40) ? 3 : (j <= 70) ? 8 : (j <= 90) ? 5 : 2;
            up = (j >= 33 && j < 40) || (j >= 60 && j < 70) || (j >= 83 && j < 90);
            step(3, {3'b100, (s < d)}, (j % 10 == 0), up);
        end
        upd = 1'b0;
        en  = 1'b0;
        step(3, POLV, 1'b0, 1'b0);

        // centre P=6 duty 2, then switch to edge P=4 duty 1 at a boundary
        cfg(6, 1'b1, 0, 0, 0, 2);
        upd = 1'b1;
        step(2, POLV, 1'b0, 1'b0);
        upd = 1'b0;
        en  = 1'b1;
        for (int j = 1; j <= 28; j++) begin
            logic b0, pe;
            upd = (j == 13);
            if (j == 13) cfg(4, 1'b0, 0, 0, 0, 1);
            if (j <= 20) begin
                b0 = cseq[(j - 1) % 10] < 2;
                pe = (j % 10 == 0);
            end else begin
                b0 = ((j - 21) % 4) < 1;
                pe = ((j - 20) % 4 == 0);
            end
            step(2, {3'b001, b0}, pe, (j >= 13 && j < 20));
        end
        upd = 1'b0;
        en  = 1'b0;
        step(2, POLV, 1'b0, 1'b0);

        // degenerate P=1 then P=0: boundary every cycle
        cfg(1, 1'b0, 0, 0, 0, 1);
        upd = 1'b1;
        step(5, POLV, 1'b0, 1'b0);
        upd = 1'b0;
        en  = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            upd = (j == 4);
            if (j == 4) cfg(0, 1'b0, 0, 0, 0, 0);
            step(5, {3'b001, (j <= 5)}, 1'b1, (j == 4));
        end
        upd = 1'b0;
        en  = 1'b0;
        step(5, POLV, 1'b0, 1'b0);

        // asynchronous reset with an update pending
        cfg(10, 1'b0, 0, 0, 0, 3);
        upd = 1'b1;
        step(6, POLV, 1'b0, 1'b0);
        upd = 1'b0;
        en  = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            upd = (j == 5);
            if (j == 5) duty_in[CNT_W-1:0] = CNT_W'(7);
            step(6, {3'b001, ((j - 1) < 3)}, 1'b0, (j >= 5));
        end
        upd = 1'b0;
        @(negedge CLK);
        #1;
        Rstn = 1'b0;
        q.push_back('{cyc + 1, 6, {POLV, 1'b0, 1'b0}});
        tick();
        Rstn = 1'b1;
        for (int j = 1; j <= 20; j++) step(6, POLV, 1'b0, 1'b0);

        en = 1'b0;
        repeat (3) tick();
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
